palette_lookup_arbiter: RTL and testbench
=========================================

Name: palette_lookup_arbiter

Overview:
Shares a single combinational 16-entry sprite palette between several sprite requesters: player ship, enemy, ammo and explosion. Each requester presents a 4-bit colour index with a valid/ready handshake. The block grants one requester per cycle in round-robin order, drives the shared palette's index input from a registered stage, and returns the tagged 12-bit RGB result with a transparency flag to the pixel compositor. It sits between the per-sprite ROM readers and the VGA colour mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 4, palette index width
COLOR_W, 4, width of each colour channel
TRANSP_IDX, 0, palette index that is treated as transparent (chroma key)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_index  in  NUM_REQ*IDX_W  per-requester index; requester r occupies bits [r*IDX_W +: IDX_W]
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when req_valid[r] & req_ready[r]
pal_index  out  IDX_W  index driven to the shared palette ROM
pal_red  in  COLOR_W  palette red channel, combinational from pal_index
pal_green  in  COLOR_W  palette green channel
pal_blue  in  COLOR_W  palette blue channel
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream accept
rsp_id  out  clog2(NUM_REQ)  requester number of the response
rsp_red  out  COLOR_W  red channel of the response
rsp_green  out  COLOR_W  green channel of the response
rsp_blue  out  COLOR_W  blue channel of the response
rsp_transparent  out  1  asserted when the looked-up index == TRANSP_IDX

Behaviour:
- Clk is the only clock. Reset is asynchronous and active-high.
- Reset clears s1_valid, s2_valid, rr_ptr, pal_index, rsp_id, the rsp colour channels and rsp_transparent to 0. req_ready is 0 during reset.
- Pipeline:
  - Stage 0 (combinational): round-robin grant.
  - Stage 1 (register): id and index; pal_index = s1_index.
  - Stage 2 (register): id, the captured pal_red/pal_green/pal_blue, and (s1_index == TRANSP_IDX).
- Latency: response appears exactly 2 cycles after the accepting edge when there is no stall. Throughput is 1 lookup per cycle.
- Advance rules:
  - adv2 = !s2_valid | rsp_ready
  - adv1 = !s1_valid | adv2
  - s2 loads from s1 when adv2; s2_valid <= s1_valid.
  - s1 loads the granted request when adv1; s1_valid <= |(req_valid).
- Grant: the first r with req_valid[r], searching from rr_ptr upward and wrapping from NUM_REQ-1 to 0.
  - req_ready[r] = (r == grant) & |req_valid & adv1. It is never asserted for a non-valid requester.
- rr_ptr update:
  - On an accept, rr_ptr <= grant+1, wrapping to 0 after NUM_REQ-1.
  - With no accept (no valid, or stalled), rr_ptr holds.
- Stall: while rsp_valid & !rsp_ready, all rsp_* outputs and pal_index hold stable and no data is lost. With both stages full, req_ready is all-zero.
- Requester rule: req_valid may not drop, and req_index must stay stable, until that requester is accepted. The arbiter does not check this.
- A single requester that is continuously valid is accepted every cycle. With k requesters continuously valid, each is accepted once every k cycles.
- Reset asserted mid-operation: in-flight lookups are discarded, rsp_valid drops immediately, and after deassertion the first grant search starts from requester 0.
- No arithmetic beyond the pointer increment, which is modulo NUM_REQ including non-power-of-two values.

Decomposition:
- Package sprite_pkg holds:
  - localparams IDX_W=4, COLOR_W=4, TRANSP_IDX=0, NUM_SPRITE_REQ=4
  - typedef rgb_t as a packed struct {red, green, blue}
  - enum req_id_t {REQ_PLAYER=0, REQ_ENEMY=1, REQ_AMMO=2, REQ_EXPLOSION=3}
- One sub-module, rr_arbiter, contains the combinational grant and the rr_ptr register and is parameterised by NUM_REQ. The pipeline registers live in the top module.

Test Plan:
1. Reset, then req_valid=0001 with index 3, rsp_ready=1, palette = team ammo palette -> req_ready=0001 on the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, RGB=F,9,F, rsp_transparent=0.
2. req_valid=1111 held for 8 cycles, rsp_ready=1 -> accepts in order 0,1,2,3,0,1,2,3; rsp_id follows the same sequence, delayed 2 cycles.
3. Requester 2 with index 0 -> rsp_transparent=1, RGB=2,B,4.
4. Fill the pipeline, then rsp_ready=0 for 5 cycles -> req_ready=0000 and rsp outputs frozen; after release, the responses drain in order with none dropped or duplicated.
5. Reset pulse while 2 lookups are in flight -> rsp_valid=0 immediately; after release, with req_valid=1010, requester 1 is granted first.
6. NUM_REQ=3 with all requesters valid -> grant order 0,1,2,0, confirming the pointer wraps correctly for a non-power-of-two count.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite palette types and widths for the sprite pixel path.
package sprite_pkg;

    localparam int unsigned IDX_W          = 4;
    localparam int unsigned COLOR_W        = 4;
    localparam int unsigned TRANSP_IDX     = 0;
    localparam int unsigned NUM_SPRITE_REQ = 4;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        REQ_PLAYER    = 2'd0,
        REQ_ENEMY     = 2'd1,
        REQ_AMMO      = 2'd2,
        REQ_EXPLOSION = 2'd3
    } req_id_t;

endpackage

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner on each accept.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_advance,
    output logic               o_any_valid_c,
    output logic [ID_W-1:0]    o_grant_c
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_hi_id;
    logic [ID_W-1:0] w_lo_id;
    logic            w_hi_found;

    // Lowest valid at/above the pointer wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        w_hi_id    = '0;
        w_lo_id    = '0;
        w_hi_found = 1'b0;
        for (int r = int'(NUM_REQ) - 1; r >= 0; r--) begin
            if (i_req_valid[r]) begin
                w_lo_id = ID_W'(r);
                if (ID_W'(r) >= r_ptr) begin
                    w_hi_id    = ID_W'(r);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    assign o_any_valid_c = |i_req_valid;
    assign o_grant_c     = w_hi_found ? w_hi_id : w_lo_id;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_any_valid_c) begin
            r_ptr <= (o_grant_c == ID_W'(NUM_REQ - 1)) ? '0 : o_grant_c + ID_W'(1);
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Time-shares one combinational sprite palette between several requesters through a
// two-stage pipeline (index register, then captured colour) with full backpressure.
module palette_lookup_arbiter #(
    parameter  int unsigned NUM_REQ    = sprite_pkg::NUM_SPRITE_REQ,
    parameter  int unsigned TRANSP_IDX = sprite_pkg::TRANSP_IDX,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [NUM_REQ-1:0]                       i_req_valid,
    input  logic [NUM_REQ*sprite_pkg::IDX_W-1:0]     i_req_index,
    output logic [NUM_REQ-1:0]                       o_req_ready,
    output logic [sprite_pkg::IDX_W-1:0]             o_pal_index,
    input  logic [sprite_pkg::COLOR_W-1:0]           i_pal_red,
    input  logic [sprite_pkg::COLOR_W-1:0]           i_pal_green,
    input  logic [sprite_pkg::COLOR_W-1:0]           i_pal_blue,
    output logic                                     o_rsp_valid,
    input  logic                                     i_rsp_ready,
    output logic [ID_W-1:0]                          o_rsp_id,
    output logic [sprite_pkg::COLOR_W-1:0]           o_rsp_red,
    output logic [sprite_pkg::COLOR_W-1:0]           o_rsp_green,
    output logic [sprite_pkg::COLOR_W-1:0]           o_rsp_blue,
    output logic                                     o_rsp_transparent
);

    import sprite_pkg::*;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_any_valid;
    logic [ID_W-1:0]  w_grant;
    logic [IDX_W-1:0] w_sel_index;

    logic             r_s1_valid;
    logic [ID_W-1:0]  r_s1_id;
    logic [IDX_W-1:0] r_s1_index;

    logic             r_s2_valid;
    logic [ID_W-1:0]  r_s2_id;
    rgb_t             r_s2_rgb;
    logic             r_s2_transp;

    assign w_adv2 = !r_s2_valid || i_rsp_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_clk         (i_clk),
        .i_rst         (i_reset),
        .i_req_valid   (i_req_valid),
        .i_advance     (w_adv1),
        .o_any_valid_c (w_any_valid),
        .o_grant_c     (w_grant)
    );

    // One-hot ready to the winner only, and only when stage 1 can take it.
    always_comb begin
        o_req_ready = '0;
        w_sel_index = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (ID_W'(r) == w_grant) begin
                o_req_ready[r] = w_any_valid && w_adv1 && !i_reset;
                w_sel_index    = i_req_index[r*IDX_W +: IDX_W];
            end
        end
    end

    // Stage 1 drives the palette address.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_index <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= w_any_valid;
            r_s1_id    <= w_grant;
            r_s1_index <= w_sel_index;
        end
    end

    // Stage 2 captures the palette's combinational colour for the compositor.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_id     <= '0;
            r_s2_rgb    <= '0;
            r_s2_transp <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid     <= r_s1_valid;
            r_s2_id        <= r_s1_id;
            r_s2_rgb.red   <= i_pal_red;
            r_s2_rgb.green <= i_pal_green;
            r_s2_rgb.blue  <= i_pal_blue;
            r_s2_transp    <= (r_s1_index == IDX_W'(TRANSP_IDX));
        end
    end

    assign o_pal_index       = r_s1_index;
    assign o_rsp_valid       = r_s2_valid;
    assign o_rsp_id          = r_s2_id;
    assign o_rsp_red         = r_s2_rgb.red;
    assign o_rsp_green       = r_s2_rgb.green;
    assign o_rsp_blue        = r_s2_rgb.blue;
    assign o_rsp_transparent = r_s2_transp;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: a 4-requester instance with a response
// scoreboard and a 3-requester instance for non-power-of-two pointer wrap.
module tb_palette_lookup_arbiter;

    import sprite_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [3:0]  req_valid;
    logic [15:0] req_index;
    logic [3:0]  req_ready;
    logic [3:0]  pal_index;
    logic [3:0]  pal_r, pal_g, pal_b;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_r, rsp_g, rsp_b;
    logic        rsp_tr;

    logic [2:0]  req_valid3;
    logic [11:0] req_index3;
    logic [2:0]  req_ready3;
    logic [3:0]  pal_index3;
    logic [3:0]  pal_r3, pal_g3, pal_b3;
    logic        rsp_valid3, rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [3:0]  rsp_r3, rsp_g3, rsp_b3;
    logic        rsp_tr3;

    int n_checks = 0;
    int n_fail   = 0;

    // Ammo palette: entry 0 is the chroma-key green, entry 3 the magenta flash.
    function automatic logic [11:0] pal_fn(input logic [3:0] i);
        case (i)
            4'h0:    pal_fn = 12'h2B4;
            4'h3:    pal_fn = 12'hF9F;
            default: pal_fn = {i, ~i, i ^ 4'h5};
        endcase
    endfunction

    assign {pal_r,  pal_g,  pal_b}  = pal_fn(pal_index);
    assign {pal_r3, pal_g3, pal_b3} = pal_fn(pal_index3);

    palette_lookup_arbiter dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_req_valid       (req_valid),
        .i_req_index       (req_index),
        .o_req_ready       (req_ready),
        .o_pal_index       (pal_index),
        .i_pal_red         (pal_r),
        .i_pal_green       (pal_g),
        .i_pal_blue        (pal_b),
        .o_rsp_valid       (rsp_valid),
        .i_rsp_ready       (rsp_ready),
        .o_rsp_id          (rsp_id),
        .o_rsp_red         (rsp_r),
        .o_rsp_green       (rsp_g),
        .o_rsp_blue        (rsp_b),
        .o_rsp_transparent (rsp_tr)
    );

    palette_lookup_arbiter #(.NUM_REQ(3)) dut3 (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_req_valid       (req_valid3),
        .i_req_index       (req_index3),
        .o_req_ready       (req_ready3),
        .o_pal_index       (pal_index3),
        .i_pal_red         (pal_r3),
        .i_pal_green       (pal_g3),
        .i_pal_blue        (pal_b3),
        .o_rsp_valid       (rsp_valid3),
        .i_rsp_ready       (rsp_ready3),
        .o_rsp_id          (rsp_id3),
        .o_rsp_red         (rsp_r3),
        .o_rsp_green       (rsp_g3),
        .o_rsp_blue        (rsp_b3),
        .o_rsp_transparent (rsp_tr3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    exp_t sb[$];

    // Scoreboard: every accepted request must come back once, in order, with the model colour.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] ix;
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", 32'(rsp_id), 32'(e.id));
                    check("sb_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'(e.rgb));
                    check("sb_transp", 32'(rsp_tr), 32'(e.tr));
                end
            end
            check("ready_only_valid", 32'(req_ready & ~req_valid), 32'd0);
            for (int r = 0; r < 4; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    ix = req_index[r*4 +: 4];
                    e.id  = 2'(r);
                    e.rgb = pal_fn(ix);
                    e.tr  = (ix == 4'h0);
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_index  = 16'h0;
        rsp_ready  = 1'b1;
        req_valid3 = 3'b111;
        req_index3 = 12'h0;
        rsp_ready3 = 1'b1;
        repeat (2) tick();

        // Reset state, with requests held high to show ready stays low.
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_req_ready3", 32'(req_ready3), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_pal_index", 32'(pal_index), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'd0);
        check("rst_transp", 32'(rsp_tr), 32'd0);

        // 1: single lookup, two-cycle latency.
        req_valid3 = 3'b000;
        rst        = 1'b0;
        req_valid  = 4'b0001;
        req_index  = 16'h0003;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        #1;
        check("t1_pal_index", 32'(pal_index), 32'd3);
        check("t1_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'(REQ_PLAYER));
        check("t1_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'hF9F);
        check("t1_transp", 32'(rsp_tr), 32'd0);
        tick();
        check("t1_rsp_done", 32'(rsp_valid), 32'd0);

        // 2: all four valid from a fresh pointer -> strict rotation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_index = {4'h8, 4'h7, 4'h6, 4'h5};
        for (int i = 0; i < 10; i++) begin
            req_valid = (i < 8) ? 4'hF : 4'h0;
            #1;
            if (i < 8) check("t2_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            if (i >= 2) begin
                check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
                check("t2_rsp_id", 32'(rsp_id), 32'((i - 2) % 4));
            end
            tick();
        end
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // 3: chroma-key index from the ammo requester.
        req_index = {4'h8, 4'h0, 4'h6, 4'h5};
        req_valid = 4'b0100;
        #1;
        check("t3_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        tick();
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t3_rsp_id", 32'(rsp_id), 32'(REQ_AMMO));
        check("t3_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'h2B4);
        check("t3_transp", 32'(rsp_tr), 32'd1);
        tick();

        // 4: fill both stages, stall five cycles, then drain.
        rsp_ready = 1'b0;
        req_index = {4'hC, 4'hA, 4'hB, 4'h9};
        req_valid = 4'hF;
        #1;
        check("t4_ready_a", 32'(req_ready), 32'b1000);
        tick();
        check("t4_ready_b", 32'(req_ready), 32'b0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_stall_valid", 32'(rsp_valid), 32'd1);
            check("t4_stall_id", 32'(rsp_id), 32'(REQ_EXPLOSION));
            check("t4_stall_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'(pal_fn(4'hC)));
            check("t4_stall_pal_index", 32'(pal_index), 32'h9);
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        #1;
        check("t4_drain0_id", 32'(rsp_id), 32'd3);
        tick();
        check("t4_drain1_valid", 32'(rsp_valid), 32'd1);
        check("t4_drain1_id", 32'(rsp_id), 32'd0);
        check("t4_drain1_rgb", 32'({rsp_r, rsp_g, rsp_b}), 32'(pal_fn(4'h9)));
        tick();
        check("t4_drain_done", 32'(rsp_valid), 32'd0);

        // 5: reset with two lookups in flight, then restart from requester 0.
        req_valid = 4'hF;
        tick();
        tick();
        check("t5_inflight", 32'(rsp_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_pal_index", 32'(pal_index), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'b0010);
        tick();
        check("t5_second_grant", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'h0;
        repeat (3) tick();

        // 6: three requesters, pointer wraps 2 -> 0.
        req_index3 = 12'h321;
        for (int i = 0; i < 6; i++) begin
            req_valid3 = (i < 4) ? 3'b111 : 3'b000;
            #1;
            if (i < 4) check("t6_ready", 32'(req_ready3), 32'(3'b001 << (i % 3)));
            if (i >= 2) begin
                check("t6_rsp_valid", 32'(rsp_valid3), 32'd1);
                check("t6_rsp_id", 32'(rsp_id3), 32'((i - 2) % 3));
            end
            if (i == 2) begin
                check("t6_rgb", 32'({rsp_r3, rsp_g3, rsp_b3}), 32'(pal_fn(4'h1)));
                check("t6_transp", 32'(rsp_tr3), 32'd0);
            end
            tick();
        end

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
